alu_logic: RTL and testbench
============================

ALU_LOGIC -- requirements
Module: alu_logic

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal range 1..64.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  high when x, y and logic_function carry an operation to execute this cycle.
REQ-005 x  input  WIDTH  first operand.
REQ-006 y  input  WIDTH  second operand.
REQ-007 logic_function  input  3  operation select, encoding per REQ-010.
REQ-008 logic_output  output  WIDTH  registered result.
REQ-009 out_valid  output  1  high for exactly the cycle(s) in which logic_output holds a new result; also outputs zero_flag and parity_flag (1 bit each, see REQ-016).

Function
REQ-010 Opcode map, bitwise over all WIDTH bits:
- 0 = x AND y
- 1 = x OR y
- 2 = x XOR y
- 3 = NOT (x OR y)
- 4 = NOT x
- 5 = NOT (x XOR y)
- 6 = NOT (x AND y)
- 7 = x (pass-through)
REQ-011 Latency exactly one cycle: a rising edge with in_valid=1 loads the result into logic_output, and out_valid=1 follows in the next cycle.
REQ-012 A rising edge with in_valid=0 holds logic_output unchanged and clears out_valid to 0.
REQ-013 Back-to-back operations are accepted every cycle, so throughput is one per clock; no stall or backpressure exists.
REQ-014 Operands are unsigned bit vectors: there is no carry, overflow or sign extension, and y is ignored by opcodes 4 and 7.
REQ-015 An opcode containing X/Z bits while in_valid=1 is a protocol violation. With in_valid=0, the opcode value is don't-care and has no effect.

Reset
REQ-016 While rst_n=0, independent of clk:
- logic_output = 0
- out_valid = 0
- zero_flag = 0
- parity_flag = 0
REQ-017 Deasserting rst_n takes effect synchronously at the next rising edge. The first operation can be captured at the first rising edge after rst_n is sampled high.
REQ-018 If reset asserts while an operation is pending, that operation is discarded with no partial output.

Configuration
REQ-019 With macro ALU_LOGIC_FLAGS_EN defined, the flags are registered alongside logic_output, with the same latency and the same hold behaviour:
- zero_flag = 1 when the result equals all-zeros
- parity_flag = XOR-reduction of the result
REQ-020 Without ALU_LOGIC_FLAGS_EN, the zero_flag and parity_flag ports still exist but are driven constant 0 and no flag logic is synthesised.

Structure
REQ-021 Shared package alu_logic_pkg holds:
- the 3-bit opcode enumeration (LOGIC_AND, LOGIC_OR, LOGIC_XOR, LOGIC_NOR, LOGIC_NOT, LOGIC_XNOR, LOGIC_NAND, LOGIC_PASS)
- the default width constant 32
REQ-022 One combinational sub-module, alu_logic_core, computes the result and the optional flags from x, y and logic_function. alu_logic wraps it with the output and valid registers.

Verification
REQ-023 x=1, y=4, op 0, in_valid=1 -> next cycle logic_output=0x00000000, out_valid=1, zero_flag=1 (flags enabled).
REQ-024 x=1, y=5, op 2 -> 0x00000004. Then x=6, y=8, op 1 -> 0x0000000E, on consecutive cycles with out_valid held high.
REQ-025 x=0xFFFFFFFF, y=5, op 4 -> 0x00000000. Then x=1, y=5, op 3 -> 0xFFFFFFFA, parity_flag=0 (flags enabled).
REQ-026 Load 0x0000000E, then drive in_valid=0 with changing operands for 3 cycles -> logic_output stays 0x0000000E and out_valid=0.
REQ-027 Assert rst_n=0 mid-cycle between edges -> logic_output and out_valid go to 0 immediately, with no clock edge.
REQ-028 Without ALU_LOGIC_FLAGS_EN, repeat REQ-023 -> zero_flag=0 and parity_flag=0, with the result unchanged.

Source files
------------

// File: rtl/alu_logic_pkg.sv
// rtl/alu_logic_pkg.sv - shared opcode enumeration and default width for alu_logic
package alu_logic_pkg;

   localparam int ALU_DEFAULT_WIDTH = 32;

   typedef enum logic [2:0] {
      LOGIC_AND  = 3'd0,
      LOGIC_OR   = 3'd1,
      LOGIC_XOR  = 3'd2,
      LOGIC_NOR  = 3'd3,
      LOGIC_NOT  = 3'd4,
      LOGIC_XNOR = 3'd5,
      LOGIC_NAND = 3'd6,
      LOGIC_PASS = 3'd7
   } logic_op_e;

endpackage

// File: rtl/alu_logic_if.sv
// rtl/alu_logic_if.sv - operation request / registered result bundle for alu_logic
//   in_valid, x, y, logic_function : request (master -> slave)
//   logic_output, out_valid        : registered result (slave -> master)
//   zero_flag, parity_flag         : result flags, constant 0 unless ALU_LOGIC_FLAGS_EN
interface alu_logic_if
   import alu_logic_pkg::*;
#(
   parameter int WIDTH = ALU_DEFAULT_WIDTH
);
   logic             in_valid;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [2:0]       logic_function;
   logic [WIDTH-1:0] logic_output;
   logic             out_valid;
   logic             zero_flag;
   logic             parity_flag;

   modport master (
      output in_valid, x, y, logic_function,
      input  logic_output, out_valid, zero_flag, parity_flag
   );

   modport slave (
      input  in_valid, x, y, logic_function,
      output logic_output, out_valid, zero_flag, parity_flag
   );
endinterface

// File: rtl/alu_logic_core.sv
// rtl/alu_logic_core.sv - combinational bitwise logic unit with optional result flags
//   x, y           : operands (WIDTH bits, unsigned)
//   logic_function : opcode (logic_op_e)
//   result         : bitwise result
//   zero_flag, parity_flag : present only with ALU_LOGIC_FLAGS_EN
module alu_logic_core
   import alu_logic_pkg::*;
#(
   parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [2:0]       logic_function,
`ifdef ALU_LOGIC_FLAGS_EN
   output logic             zero_flag,
   output logic             parity_flag,
`endif
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = x;
      case (logic_op_e'(logic_function))
         LOGIC_AND:  result = x & y;
         LOGIC_OR:   result = x | y;
         LOGIC_XOR:  result = x ^ y;
         LOGIC_NOR:  result = ~(x | y);
         LOGIC_NOT:  result = ~x;
         LOGIC_XNOR: result = ~(x ^ y);
         LOGIC_NAND: result = ~(x & y);
         LOGIC_PASS: result = x;
         default:    result = x;
      endcase
   end

`ifdef ALU_LOGIC_FLAGS_EN
   assign zero_flag   = (result == '0);
   assign parity_flag = ^result;
`endif

endmodule

// File: rtl/alu_logic.sv
// rtl/alu_logic.sv - one-cycle registered bitwise ALU (flags with ALU_LOGIC_FLAGS_EN)
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_logic_if.slave (request in, registered result/valid/flags out)
module alu_logic
   import alu_logic_pkg::*;
#(
   parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_logic_if.slave  bus
);

   logic [WIDTH-1:0] core_result;
   logic [WIDTH-1:0] logic_output_d, logic_output_q;
   logic             out_valid_d, out_valid_q;

`ifdef ALU_LOGIC_FLAGS_EN
   logic core_zero, core_parity;
   logic zero_flag_d, zero_flag_q;
   logic parity_flag_d, parity_flag_q;
`endif

   alu_logic_core #(.WIDTH(WIDTH)) u_core (
      .x              (bus.x),
      .y              (bus.y),
      .logic_function (bus.logic_function),
`ifdef ALU_LOGIC_FLAGS_EN
      .zero_flag      (core_zero),
      .parity_flag    (core_parity),
`endif
      .result         (core_result)
   );

   // Result and flags only load on a valid request; otherwise they hold.
   always_comb begin
      logic_output_d = logic_output_q;
      out_valid_d    = bus.in_valid;
      if (bus.in_valid) begin
         logic_output_d = core_result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         logic_output_q <= '0;
         out_valid_q    <= 1'b0;
      end else begin
         logic_output_q <= logic_output_d;
         out_valid_q    <= out_valid_d;
      end
   end

`ifdef ALU_LOGIC_FLAGS_EN
   always_comb begin
      zero_flag_d   = zero_flag_q;
      parity_flag_d = parity_flag_q;
      if (bus.in_valid) begin
         zero_flag_d   = core_zero;
         parity_flag_d = core_parity;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_flag_q   <= 1'b0;
         parity_flag_q <= 1'b0;
      end else begin
         zero_flag_q   <= zero_flag_d;
         parity_flag_q <= parity_flag_d;
      end
   end

   assign bus.zero_flag   = zero_flag_q;
   assign bus.parity_flag = parity_flag_q;
`else
   assign bus.zero_flag   = 1'b0;
   assign bus.parity_flag = 1'b0;
`endif

   assign bus.logic_output = logic_output_q;
   assign bus.out_valid    = out_valid_q;

endmodule

// File: tb/tb_alu_logic.sv
// tb/tb_alu_logic.sv - self-checking bench for alu_logic (directed + random vs reference model)
module tb_alu_logic;
   import alu_logic_pkg::*;

   localparam int W = 32;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   // Reference state: what the outputs must show after each edge.
   logic [W-1:0] exp_out;
   logic         exp_valid;
   logic         exp_zero;
   logic         exp_parity;

   alu_logic_if #(.WIDTH(W)) bus ();

   alu_logic #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Opcode table evaluated one bit position at a time from its truth table.
   function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      int ones;
      r = '0;
      for (int i = 0; i < W; i++) begin
         ones = int'(a[i]) + int'(b[i]);
         case (op)
            0: r[i] = (ones == 2);
            1: r[i] = (ones >= 1);
            2: r[i] = (ones == 1);
            3: r[i] = (ones == 0);
            4: r[i] = (a[i] == 1'b0);
            5: r[i] = (ones != 1);
            6: r[i] = (ones != 2);
            default: r[i] = a[i];
         endcase
      end
      return r;
   endfunction

   function automatic logic ref_parity(input logic [W-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < W; i++) n += int'(v[i]);
      return logic'(n % 2);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".out"},    64'(bus.logic_output), 64'(exp_out));
      check({tag, ".valid"},  64'(bus.out_valid),    64'(exp_valid));
      check({tag, ".zero"},   64'(bus.zero_flag),    64'(exp_zero));
      check({tag, ".parity"}, 64'(bus.parity_flag),  64'(exp_parity));
   endtask

   task automatic model_reset();
      exp_out    = '0;
      exp_valid  = 1'b0;
      exp_zero   = 1'b0;
      exp_parity = 1'b0;
   endtask

   // Drive one request, clock it, update the model, compare outputs.
   task automatic step(input string tag, input logic iv, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2:0] f);
      bus.in_valid       = iv;
      bus.x              = a;
      bus.y              = b;
      bus.logic_function = f;
      @(posedge clk);
      #1;
      exp_valid = iv;
      if (iv) begin
         exp_out = ref_op(int'(f), a, b);
`ifdef ALU_LOGIC_FLAGS_EN
         exp_zero   = (exp_out == 0);
         exp_parity = ref_parity(exp_out);
`endif
      end
      check_all(tag);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.in_valid       = 1'b0;
      bus.x              = '0;
      bus.y              = '0;
      bus.logic_function = 3'd0;
      model_reset();
      #3;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed scenarios
      step("and_zero",  1'b1, 32'd1, 32'd4, LOGIC_AND);
      step("xor",       1'b1, 32'd1, 32'd5, LOGIC_XOR);
      step("or",        1'b1, 32'd6, 32'd8, LOGIC_OR);
      step("not",       1'b1, 32'hFFFF_FFFF, 32'd5, LOGIC_NOT);
      step("nor",       1'b1, 32'd1, 32'd5, LOGIC_NOR);
      check("nor_value", 64'(bus.logic_output), 64'h0000_0000_FFFF_FFFA);
      step("load_e",    1'b1, 32'd6, 32'd8, LOGIC_OR);
      step("hold0",     1'b0, 32'h1234_5678, 32'h9ABC_DEF0, LOGIC_NAND);
      step("hold1",     1'b0, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 3'bxxx);
      step("hold2",     1'b0, 32'hFFFF_FFFF, 32'h0, LOGIC_XNOR);
      check("hold_value", 64'(bus.logic_output), 64'h0000_0000_0000_000E);
      step("xnor",      1'b1, 32'hA5A5_0000, 32'h5A5A_FFFF, LOGIC_XNOR);
      step("nand",      1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LOGIC_NAND);
      step("pass",      1'b1, 32'h8000_0001, 32'hFFFF_FFFF, LOGIC_PASS);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         step("rand", ($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
              3'($urandom_range(0, 7)));
      end

      // Asynchronous reset between edges, with a request pending
      step("pre_rst", 1'b1, 32'hCAFE_F00D, 32'h0, LOGIC_PASS);
      bus.in_valid = 1'b1;
      bus.x        = 32'h1111_1111;
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge clk);
      #1;
      check_all("rst_held");
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst", 1'b1, 32'h0000_00F0, 32'h0000_0FF0, LOGIC_AND);
      step("post_idle", 1'b0, 32'h0, 32'h0, LOGIC_AND);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
